// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin sharing of one synchronous-read RAM between a CPU port (0)
// and a line-fill port (1), with a lock for atomic fills and a fixed-latency response pipe.
module ram_arbiter #(
  parameter int MEM_ADDR_WIDTH      = 7,
  parameter int MEM_DATA_WIDTH      = 32,
  parameter int MEM_DATA_SIZE_BYTES = 4,
  parameter int RD_LATENCY          = 1
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           p0_valid,
  output logic                           p0_ready,
  input  logic [MEM_ADDR_WIDTH-1:0]      p0_addr,
  input  logic                           p0_wen,
  input  logic [MEM_DATA_SIZE_BYTES-1:0] p0_ben,
  input  logic [MEM_DATA_WIDTH-1:0]      p0_wdata,
  input  logic                           p0_lock,
  output logic                           p0_resp_valid,
  output logic [MEM_DATA_WIDTH-1:0]      p0_resp_rdata,
  input  logic                           p1_valid,
  output logic                           p1_ready,
  input  logic [MEM_ADDR_WIDTH-1:0]      p1_addr,
  input  logic                           p1_wen,
  input  logic [MEM_DATA_SIZE_BYTES-1:0] p1_ben,
  input  logic [MEM_DATA_WIDTH-1:0]      p1_wdata,
  input  logic                           p1_lock,
  output logic                           p1_resp_valid,
  output logic [MEM_DATA_WIDTH-1:0]      p1_resp_rdata,
  output logic [MEM_ADDR_WIDTH-1:0]      ram_addr,
  output logic                           ram_wen,
  output logic [MEM_DATA_SIZE_BYTES-1:0] ram_ben,
  output logic [MEM_DATA_WIDTH-1:0]      ram_wdata,
  input  logic [MEM_DATA_WIDTH-1:0]      ram_rdata,
  output logic                           misalign
);

  // state    | meaning
  // ST_IDLE  | round-robin between both ports
  // ST_LOCK0 | port 0 owns the RAM until it completes a beat with lock=0
  // ST_LOCK1 | port 1 owns the RAM until it completes a beat with lock=0
  typedef enum logic [1:0] {ST_IDLE, ST_LOCK0, ST_LOCK1} state_t;

  state_t r_state;
  state_t w_state_next;
  logic   r_last_grant;
  logic   r_misalign;
  logic   w_gnt0;
  logic   w_gnt1;
  logic   w_hs;
  logic   w_hs_port;
  logic   w_hs_wr;
  logic [MEM_ADDR_WIDTH-1:0] w_sel_addr;

  logic [RD_LATENCY-1:0] r_pipe_vld;
  logic [RD_LATENCY-1:0] r_pipe_port;
  logic [RD_LATENCY-1:0] r_pipe_wr;
  logic                  w_resp_vld;
  logic                  w_resp_port;
  logic [MEM_DATA_WIDTH-1:0] w_resp_data;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_gnt0       = 1'b0;
    w_gnt1       = 1'b0;
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        // on a tie, the port that did not win last time goes first
        w_gnt0 = p0_valid && (!p1_valid || r_last_grant);
        w_gnt1 = p1_valid && (!p0_valid || !r_last_grant);
      end
      ST_LOCK0: w_gnt0 = p0_valid;
      ST_LOCK1: w_gnt1 = p1_valid;
      default:  w_state_next = ST_IDLE;
    endcase
    if (!reset_n) begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
    end
    if (w_gnt0) begin
      w_state_next = p0_lock ? ST_LOCK0 : ST_IDLE;
    end else if (w_gnt1) begin
      w_state_next = p1_lock ? ST_LOCK1 : ST_IDLE;
    end
  end

  assign p0_ready = w_gnt0;
  assign p1_ready = w_gnt1;

  always_comb begin
    w_hs       = 1'b0;
    w_hs_port  = 1'b0;
    w_hs_wr    = 1'b0;
    w_sel_addr = '0;
    ram_wen    = 1'b0;
    ram_ben    = '0;
    ram_wdata  = '0;
    if (w_gnt0) begin
      w_hs       = 1'b1;
      w_hs_wr    = p0_wen;
      w_sel_addr = p0_addr;
      ram_wen    = p0_wen;
      ram_ben    = p0_ben;
      ram_wdata  = p0_wdata;
    end else if (w_gnt1) begin
      w_hs       = 1'b1;
      w_hs_port  = 1'b1;
      w_hs_wr    = p1_wen;
      w_sel_addr = p1_addr;
      ram_wen    = p1_wen;
      ram_ben    = p1_ben;
      ram_wdata  = p1_wdata;
    end
  end

  assign ram_addr = {w_sel_addr[MEM_ADDR_WIDTH-1:2], 2'b00};

  // a reset flushes the response pipe so in-flight requests never answer
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_last_grant <= 1'b1;
      r_misalign   <= 1'b0;
      r_pipe_vld   <= '0;
      r_pipe_port  <= '0;
      r_pipe_wr    <= '0;
    end else begin
      if (w_hs) begin
        r_last_grant <= w_hs_port;
      end
      r_misalign     <= w_hs && (w_sel_addr[1:0] != 2'b00);
      r_pipe_vld[0]  <= w_hs;
      r_pipe_port[0] <= w_hs_port;
      r_pipe_wr[0]   <= w_hs_wr;
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_pipe_vld[i]  <= r_pipe_vld[i-1];
        r_pipe_port[i] <= r_pipe_port[i-1];
        r_pipe_wr[i]   <= r_pipe_wr[i-1];
      end
    end
  end

  assign misalign    = r_misalign;
  assign w_resp_vld  = r_pipe_vld[RD_LATENCY-1];
  assign w_resp_port = r_pipe_port[RD_LATENCY-1];
  assign w_resp_data = r_pipe_wr[RD_LATENCY-1] ? '0 : ram_rdata;

  assign p0_resp_valid = w_resp_vld && !w_resp_port;
  assign p1_resp_valid = w_resp_vld && w_resp_port;
  assign p0_resp_rdata = p0_resp_valid ? w_resp_data : '0;
  assign p1_resp_rdata = p1_resp_valid ? w_resp_data : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: one instance at RD_LATENCY=1 and one at 2,
// each with its own byte-enabled synchronous-read RAM model.
`timescale 1ns/1ps
module tb_ram_arbiter;
  localparam int AW = 7;
  localparam int DW = 32;
  localparam int BW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;
  logic p0_valid, p1_valid, p0_wen, p1_wen, p0_lock, p1_lock;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [BW-1:0] p0_ben, p1_ben;
  logic [DW-1:0] p0_wdata, p1_wdata;

  logic a_p0_ready, a_p1_ready, a_p0_resp_valid, a_p1_resp_valid, a_ram_wen, a_misalign;
  logic [DW-1:0] a_p0_resp_rdata, a_p1_resp_rdata, a_ram_wdata, a_ram_rdata;
  logic [AW-1:0] a_ram_addr;
  logic [BW-1:0] a_ram_ben;

  logic b_p0_ready, b_p1_ready, b_p0_resp_valid, b_p1_resp_valid, b_ram_wen, b_misalign;
  logic [DW-1:0] b_p0_resp_rdata, b_p1_resp_rdata, b_ram_wdata, b_ram_rdata, b_rd_stage;
  logic [AW-1:0] b_ram_addr;
  logic [BW-1:0] b_ram_ben;

  logic [DW-1:0] mem_a [32];
  logic [DW-1:0] mem_b [32];

  int n_checks = 0;
  int n_fail   = 0;

  ram_arbiter #(.MEM_ADDR_WIDTH(AW), .MEM_DATA_WIDTH(DW), .MEM_DATA_SIZE_BYTES(BW), .RD_LATENCY(1)) u_dut_a (
    .clk(clk), .reset_n(reset_n),
    .p0_valid(p0_valid), .p0_ready(a_p0_ready), .p0_addr(p0_addr), .p0_wen(p0_wen),
    .p0_ben(p0_ben), .p0_wdata(p0_wdata), .p0_lock(p0_lock),
    .p0_resp_valid(a_p0_resp_valid), .p0_resp_rdata(a_p0_resp_rdata),
    .p1_valid(p1_valid), .p1_ready(a_p1_ready), .p1_addr(p1_addr), .p1_wen(p1_wen),
    .p1_ben(p1_ben), .p1_wdata(p1_wdata), .p1_lock(p1_lock),
    .p1_resp_valid(a_p1_resp_valid), .p1_resp_rdata(a_p1_resp_rdata),
    .ram_addr(a_ram_addr), .ram_wen(a_ram_wen), .ram_ben(a_ram_ben),
    .ram_wdata(a_ram_wdata), .ram_rdata(a_ram_rdata), .misalign(a_misalign)
  );

  ram_arbiter #(.MEM_ADDR_WIDTH(AW), .MEM_DATA_WIDTH(DW), .MEM_DATA_SIZE_BYTES(BW), .RD_LATENCY(2)) u_dut_b (
    .clk(clk), .reset_n(reset_n),
    .p0_valid(p0_valid), .p0_ready(b_p0_ready), .p0_addr(p0_addr), .p0_wen(p0_wen),
    .p0_ben(p0_ben), .p0_wdata(p0_wdata), .p0_lock(p0_lock),
    .p0_resp_valid(b_p0_resp_valid), .p0_resp_rdata(b_p0_resp_rdata),
    .p1_valid(p1_valid), .p1_ready(b_p1_ready), .p1_addr(p1_addr), .p1_wen(p1_wen),
    .p1_ben(p1_ben), .p1_wdata(p1_wdata), .p1_lock(p1_lock),
    .p1_resp_valid(b_p1_resp_valid), .p1_resp_rdata(b_p1_resp_rdata),
    .ram_addr(b_ram_addr), .ram_wen(b_ram_wen), .ram_ben(b_ram_ben),
    .ram_wdata(b_ram_wdata), .ram_rdata(b_ram_rdata), .misalign(b_misalign)
  );

  // RAM models; contents are (re)loaded while reset is held low
  always @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) begin
        mem_a[i] <= 32'(i) * 32'h0101_0101;
        mem_b[i] <= 32'(i) * 32'h0101_0101;
      end
      mem_a[4]  <= 32'hDEAD_BEEF;
      mem_a[8]  <= 32'hAABB_CCDD;
      mem_a[12] <= 32'h1234_5678;
      mem_b[4]  <= 32'hCAFE_F00D;
    end else begin
      if (a_ram_wen)
        for (int i = 0; i < BW; i++)
          if (a_ram_ben[i]) mem_a[a_ram_addr[AW-1:2]][8*i +: 8] <= a_ram_wdata[8*i +: 8];
      if (b_ram_wen)
        for (int i = 0; i < BW; i++)
          if (b_ram_ben[i]) mem_b[b_ram_addr[AW-1:2]][8*i +: 8] <= b_ram_wdata[8*i +: 8];
    end
    a_ram_rdata <= mem_a[a_ram_addr[AW-1:2]];
    b_rd_stage  <= mem_b[b_ram_addr[AW-1:2]];
    b_ram_rdata <= b_rd_stage;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_p0(input logic v, input logic [AW-1:0] a, input logic w,
                          input logic [BW-1:0] b, input logic [DW-1:0] d, input logic l);
    p0_valid = v; p0_addr = a; p0_wen = w; p0_ben = b; p0_wdata = d; p0_lock = l;
  endtask

  task automatic drive_p1(input logic v, input logic [AW-1:0] a, input logic w,
                          input logic [BW-1:0] b, input logic [DW-1:0] d, input logic l);
    p1_valid = v; p1_addr = a; p1_wen = w; p1_ben = b; p1_wdata = d; p1_lock = l;
  endtask

  task automatic idle_all();
    drive_p0(1'b0, '0, 1'b0, '0, '0, 1'b0);
    drive_p1(1'b0, '0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    idle_all();
    p0_valid = 1'b1;
    p1_valid = 1'b1;
    step(); step(); settle();
    check_val("rst_ready0", a_p0_ready, 0);
    check_val("rst_ready1", a_p1_ready, 0);
    check_val("rst_resp0", a_p0_resp_valid, 0);
    check_val("rst_misalign", a_misalign, 0);
    check_val("rst_ram_wen", a_ram_wen, 0);
    check_val("rst_ram_addr", a_ram_addr, 0);

    // single read
    step(); reset_n = 1'b1; idle_all();
    drive_p0(1'b1, 7'h10, 1'b0, 4'h0, 32'h0, 1'b0); settle();
    check_val("rd_ready0", a_p0_ready, 1);
    check_val("rd_ready1", a_p1_ready, 0);
    check_val("rd_ram_addr", a_ram_addr, 32'h10);
    check_val("rd_ram_wen", a_ram_wen, 0);
    step(); idle_all(); settle();
    check_val("rd_resp_v0", a_p0_resp_valid, 1);
    check_val("rd_resp_data", a_p0_resp_rdata, 32'hDEAD_BEEF);
    check_val("rd_resp_v1", a_p1_resp_valid, 0);

    // byte-enabled write then read of the same word
    step(); drive_p1(1'b1, 7'h20, 1'b1, 4'b0101, 32'h1122_3344, 1'b0); settle();
    check_val("wr_ready1", a_p1_ready, 1);
    check_val("wr_ram_wen", a_ram_wen, 1);
    check_val("wr_ram_ben", a_ram_ben, 4'b0101);
    check_val("wr_ram_wdata", a_ram_wdata, 32'h1122_3344);
    step(); drive_p1(1'b1, 7'h20, 1'b0, 4'h0, 32'h0, 1'b0); settle();
    check_val("wr_ack_v1", a_p1_resp_valid, 1);
    check_val("wr_ack_data", a_p1_resp_rdata, 0);
    check_val("wr_rd_ready1", a_p1_ready, 1);
    step(); idle_all(); settle();
    check_val("wr_rd_v1", a_p1_resp_valid, 1);
    check_val("wr_rd_data", a_p1_resp_rdata, 32'hAA22_CC44);

    // round-robin with both ports valid right after reset
    step(); reset_n = 1'b0; idle_all(); settle();
    step(); reset_n = 1'b1;
    drive_p0(1'b1, 7'h08, 1'b0, 4'h0, 32'h0, 1'b0);
    drive_p1(1'b1, 7'h0C, 1'b0, 4'h0, 32'h0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      settle();
      check_val("rr_ready0", a_p0_ready, (i % 2) == 0);
      check_val("rr_ready1", a_p1_ready, (i % 2) == 1);
      if (i > 0) begin
        check_val("rr_resp_v0", a_p0_resp_valid, (i % 2) == 1);
        check_val("rr_resp_d1", a_p1_resp_rdata, ((i % 2) == 0) ? 32'h0303_0303 : 32'h0);
      end
      step();
    end
    idle_all(); settle();
    check_val("rr_last_v1", a_p1_resp_valid, 1);
    check_val("rr_last_v0", a_p0_resp_valid, 0);

    // locked 4-beat fill on port 1 while port 0 waits
    step(); drive_p0(1'b1, 7'h10, 1'b0, 4'h0, 32'h0, 1'b0); settle();
    check_val("pre_lock_ready0", a_p0_ready, 1);
    step();
    drive_p0(1'b1, 7'h30, 1'b0, 4'h0, 32'h0, 1'b0);
    drive_p1(1'b1, 7'h40, 1'b1, 4'hF, 32'hF0F0_F0F0, 1'b1); settle();
    check_val("lk_b0_ready0", a_p0_ready, 0);
    check_val("lk_b0_ready1", a_p1_ready, 1);
    check_val("lk_b0_addr", a_ram_addr, 32'h40);
    step(); drive_p1(1'b1, 7'h44, 1'b1, 4'hF, 32'hF1F1_F1F1, 1'b1); settle();
    check_val("lk_b1_ready0", a_p0_ready, 0);
    check_val("lk_b1_ready1", a_p1_ready, 1);
    check_val("lk_b0_ack", a_p1_resp_valid, 1);
    step(); p1_valid = 1'b0; settle();
    check_val("lk_gap_ready0", a_p0_ready, 0);
    step(); drive_p1(1'b1, 7'h48, 1'b1, 4'hF, 32'hF2F2_F2F2, 1'b1); settle();
    check_val("lk_b2_ready0", a_p0_ready, 0);
    check_val("lk_b2_ready1", a_p1_ready, 1);
    step(); drive_p1(1'b1, 7'h4C, 1'b1, 4'hF, 32'hF3F3_F3F3, 1'b0); settle();
    check_val("lk_b3_ready0", a_p0_ready, 0);
    check_val("lk_b3_ready1", a_p1_ready, 1);
    step(); drive_p1(1'b0, '0, 1'b0, '0, '0, 1'b0); settle();
    check_val("lk_after_ready0", a_p0_ready, 1);
    check_val("lk_after_addr", a_ram_addr, 32'h30);
    step(); drive_p0(1'b0, '0, 1'b0, '0, '0, 1'b0);
    drive_p1(1'b1, 7'h44, 1'b0, 4'h0, 32'h0, 1'b0); settle();
    check_val("lk_p0_resp_v", a_p0_resp_valid, 1);
    check_val("lk_p0_resp_d", a_p0_resp_rdata, 32'h1234_5678);
    check_val("lk_rb_ready1", a_p1_ready, 1);
    step(); idle_all(); settle();
    check_val("lk_rb_data", a_p1_resp_rdata, 32'hF1F1_F1F1);

    // misaligned read
    step(); drive_p0(1'b1, 7'h13, 1'b0, 4'h0, 32'h0, 1'b0); settle();
    check_val("mis_ram_addr", a_ram_addr, 32'h10);
    check_val("mis_before", a_misalign, 0);
    step(); idle_all(); settle();
    check_val("mis_flag", a_misalign, 1);
    check_val("mis_resp_v", a_p0_resp_valid, 1);
    check_val("mis_resp_d", a_p0_resp_rdata, 32'hDEAD_BEEF);
    step(); settle();
    check_val("mis_clear", a_misalign, 0);

    // reset mid-flight on the two-cycle-latency instance
    step(); drive_p0(1'b1, 7'h10, 1'b0, 4'h0, 32'h0, 1'b0); settle();
    check_val("rmf_ready0", b_p0_ready, 1);
    step(); reset_n = 1'b0; p1_valid = 1'b1; settle();
    check_val("rmf_rst_ready0", b_p0_ready, 0);
    check_val("rmf_rst_ready1", b_p1_ready, 0);
    step(); reset_n = 1'b1;
    drive_p1(1'b1, 7'h14, 1'b0, 4'h0, 32'h0, 1'b0); settle();
    check_val("rmf_flushed", b_p0_resp_valid, 0);
    check_val("rmf_tie_ready0", b_p0_ready, 1);
    check_val("rmf_tie_ready1", b_p1_ready, 0);
    step(); idle_all(); settle();
    check_val("rmf_lat_early", b_p0_resp_valid, 0);
    step(); settle();
    check_val("rmf_lat_v0", b_p0_resp_valid, 1);
    check_val("rmf_lat_d0", b_p0_resp_rdata, 32'hCAFE_F00D);
    check_val("rmf_lat_v1", b_p1_resp_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
